// File: rtl/memory_unit_pkg.sv
// Shared types for the memory unit: command encoding, handshake states
// and the default acknowledge timeout.
package memory_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_READ     = 3'd1,
        OP_WRITE    = 3'd2,
        OP_LOAD_MAR = 3'd3,
        OP_LOAD_PC  = 3'd4,
        OP_INC_PC   = 3'd5,
        OP_OUT_MAR  = 3'd6,
        OP_OUT_PC   = 3'd7
    } memory_op_e;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_DONE = 2'd2
    } hs_state_e;

    localparam int MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/memory_unit_mem_handshake_fsm.sv
// External memory req/ack sequencer: IDLE -> REQ -> DONE -> IDLE.
// Ports: start/is_write/fetch/addr_in/wdata_in from the top; mem_* to
// memory; busy, mem_err, rd_oe/rd_data (DONE read data), pc_inc pulse.
module mem_handshake_fsm
    import memory_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int ACK_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  is_write,
    input  logic                  fetch,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [7:0]            wdata_in,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req,
    output logic                  busy,
    output logic                  mem_err,
    output logic                  rd_oe,
    output logic [7:0]            rd_data,
    output logic                  pc_inc
);

    localparam logic [7:0] LAST = 8'(ACK_TIMEOUT - 1);

    hs_state_e  state;
    logic [7:0] count;
    logic       fetch_q;
    logic       timed_out;

    // A completed fetch advances the PC on the edge leaving DONE.
    assign pc_inc = (state == HS_DONE) && !mem_we && fetch_q && !timed_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HS_IDLE;
            count     <= '0;
            fetch_q   <= 1'b0;
            timed_out <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            mem_err   <= 1'b0;
            rd_oe     <= 1'b0;
            rd_data   <= '0;
        end else begin
            case (state)
                HS_IDLE: begin
                    if (start) begin
                        mem_addr  <= addr_in;
                        mem_we    <= is_write;
                        mem_wdata <= wdata_in;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        count     <= '0;
                        fetch_q   <= fetch;
                        timed_out <= 1'b0;
                        state     <= HS_REQ;
                    end
                end
                HS_REQ: begin
                    // Ack is checked first so an ack on the last
                    // allowed cycle beats the timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rd_data <= mem_rdata;
                        rd_oe   <= !mem_we;
                        state   <= HS_DONE;
                    end else begin
                        count <= count + 8'd1;
                        if (count == LAST) begin
                            mem_req   <= 1'b0;
                            mem_err   <= 1'b1;
                            timed_out <= 1'b1;
                            rd_data   <= 8'hFF;
                            rd_oe     <= !mem_we;
                            state     <= HS_DONE;
                        end
                    end
                end
                HS_DONE: begin
                    rd_oe <= 1'b0;
                    busy  <= 1'b0;
                    state <= HS_IDLE;
                end
                default: state <= HS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/memory_unit.sv
// Memory unit: PC/MAR registers, command decode, bus output mux.
// Ports: memory_op/selectors/bus_in from control; bus_out/bus_oe/busy/
// mem_err to control; mem_* handshake to external byte memory.
module memory_unit
    import memory_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET    = '0,
    parameter int                    ACK_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [2:0]            memory_op,
    input  logic                  data_word_selector,
    input  logic                  bus_selector,
    input  logic [7:0]            bus_in,
    output logic [7:0]            bus_out,
    output logic                  bus_oe,
    output logic                  busy,
    output logic                  mem_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata
);

    localparam int HW = ADDR_WIDTH - 8;

    memory_op_e            op;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] mar;
    logic                  out_oe;
    logic [7:0]            out_byte;
    logic                  rd_oe;
    logic [7:0]            rd_data;
    logic                  pc_inc;
    logic                  start;

    assign op    = memory_op_e'(memory_op);
    assign start = !busy && (op == OP_READ || op == OP_WRITE);

    mem_handshake_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_fsm (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .is_write (op == OP_WRITE),
        .fetch    (!bus_selector),
        .addr_in  (bus_selector ? mar : pc),
        .wdata_in (bus_in),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_req  (mem_req),
        .busy     (busy),
        .mem_err  (mem_err),
        .rd_oe    (rd_oe),
        .rd_data  (rd_data),
        .pc_inc   (pc_inc)
    );

    // Read data (DONE) and OUT_* data can never be valid together.
    assign bus_oe  = rd_oe | out_oe;
    assign bus_out = rd_oe ? rd_data : (out_oe ? out_byte : 8'h00);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= PC_RESET;
            mar      <= '0;
            out_oe   <= 1'b0;
            out_byte <= '0;
        end else begin
            out_oe <= 1'b0;
            if (pc_inc) begin
                pc <= pc + ADDR_WIDTH'(1);
            end else if (!busy) begin
                case (op)
                    OP_LOAD_MAR: begin
                        if (data_word_selector)
                            mar[ADDR_WIDTH-1:8] <= HW'(bus_in);
                        else
                            mar[7:0] <= bus_in;
                    end
                    OP_LOAD_PC: begin
                        if (data_word_selector)
                            pc[ADDR_WIDTH-1:8] <= HW'(bus_in);
                        else
                            pc[7:0] <= bus_in;
                    end
                    OP_INC_PC: pc <= pc + ADDR_WIDTH'(1);
                    OP_OUT_MAR: begin
                        out_oe   <= 1'b1;
                        out_byte <= data_word_selector ?
                                    8'(mar[ADDR_WIDTH-1:8]) : mar[7:0];
                    end
                    OP_OUT_PC: begin
                        out_oe   <= 1'b1;
                        out_byte <= data_word_selector ?
                                    8'(pc[ADDR_WIDTH-1:8]) : pc[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
